// File: rtl/cpu_mem_resp_pkg.sv
// rtl/cpu_mem_resp_pkg.sv - shared constants for the CPU data-memory responder
//
// Purpose: FSM state encoding, minimum read latency, the positions of the
// stall fields inside random_mask, and a saturating counter helper.
// Ports: none (package).

package cpu_mem_resp_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ_STALL = 3'd1;
  localparam logic [2:0] ST_ACCEPT    = 3'd2;
  localparam logic [2:0] ST_RD_WAIT   = 3'd3;
  localparam logic [2:0] ST_RD_RESP   = 3'd4;

  localparam int RD_LAT_MIN = 1;

  // random_mask[2:0] stalls request acceptance, random_mask[4:3] stretches read return
  localparam int REQ_STALL_LSB = 0;
  localparam int REQ_STALL_MSB = 2;
  localparam int RD_STALL_LSB  = 3;
  localparam int RD_STALL_MSB  = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_mem_resp_ram.sv
// rtl/cpu_mem_resp_ram.sv - single-port byte-enable word RAM for the responder
//
// Purpose: 2**ADDR_WIDTH x 32 storage, synchronous byte-lane write,
// combinational read, no reset (contents survive responder reset).
// Ports:
//   clk_i    - clock
//   we_i     - write enable (sampled at posedge)
//   be_i     - per-byte write enables, bit n covers wdata_i[8n+7:8n]
//   addr_i   - word index, shared by read and write
//   wdata_i  - write data
//   rdata_o  - combinational read of RAM[addr_i]

module cpu_mem_resp_ram
  import cpu_mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - memory-side responder for the CPU data-memory valid/ready port
//
// Purpose: serves CPU loads/stores from an internal word RAM, inserting bounded
// pseudo-random stalls before request acceptance and before read return.
// Ports:
//   sys_clk, sys_reset_n           - clock, async-assert active-low reset
//   random_mask[4:0]               - stall source ([2:0] request, [4:3] read)
//   Address, MemWrite, Write_data,
//   Write_strb, MemRead            - CPU request
//   Mem_Req_Ready                  - one-cycle registered request accept
//   Read_data, Read_data_Valid     - read return, held until Read_data_Ready
//   Read_data_Ready                - CPU accepts read data
//   rd_cnt, wr_cnt                 - saturating completed read/write counts
//   proto_err                      - sticky protocol violation flag

module cpu_mem_responder
  import cpu_mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter bit RAND_EN    = 1'b1,
  parameter int RD_LAT     = 1
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic [4:0]  random_mask,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        proto_err
);

  localparam int          LAT_EFF  = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;
  localparam logic [15:0] LAT_BASE = 16'(LAT_EFF - 1);

  logic [2:0]            state_q, state_d;
  logic [2:0]            stall_q, stall_d;
  logic [15:0]           lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  rdy_q, rdy_d;
  logic                  vld_q, vld_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;

  logic                  req;
  logic [2:0]            req_stall;
  logic [1:0]            rd_stall;
  logic [ADDR_WIDTH-1:0] addr_idx;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_bits;

  assign req       = MemRead | MemWrite;
  assign req_stall = RAND_EN ? random_mask[REQ_STALL_MSB:REQ_STALL_LSB] : 3'd0;
  assign rd_stall  = RAND_EN ? random_mask[RD_STALL_MSB:RD_STALL_LSB] : 2'd0;
  // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
  assign addr_idx  = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  // The write lands on the handshake edge; a both-high request is treated as a write.
  assign ram_we   = (state_q == ST_ACCEPT) && MemWrite;
  assign ram_addr = (state_q == ST_ACCEPT) ? addr_idx : idx_q;

  cpu_mem_resp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (ram_we),
    .be_i    (Write_strb),
    .addr_i  (ram_addr),
    .wdata_i (Write_data),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    stall_d  = stall_q;
    lat_d    = lat_q;
    idx_d    = idx_q;
    rdy_d    = 1'b0;
    vld_d    = vld_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall_d = req_stall;
          if (req_stall != 3'd0) begin
            state_d = ST_REQ_STALL;
          end else begin
            state_d = ST_ACCEPT;
            rdy_d   = 1'b1;
          end
        end
      end
      ST_REQ_STALL: begin
        if (!req) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_d = (stall_q != 3'd0) ? stall_q - 3'd1 : 3'd0;
          // Leave once the count reaches 1; a count of 1 on entry leaves immediately.
          if (stall_q <= 3'd2) begin
            state_d = ST_ACCEPT;
            rdy_d   = 1'b1;
          end
        end
      end
      ST_ACCEPT: begin
        state_d = ST_IDLE;
        if (MemWrite) begin
          wr_cnt_d = sat_inc(wr_cnt_q);
          if (MemRead) begin
            err_d = 1'b1;
          end
        end else if (MemRead) begin
          idx_d   = addr_idx;
          lat_d   = LAT_BASE + 16'(rd_stall);
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == 16'd0) begin
          rdata_d = ram_rdata;
          vld_d   = 1'b1;
          state_d = ST_RD_RESP;
        end else begin
          lat_d = lat_q - 16'd1;
        end
      end
      ST_RD_RESP: begin
        if (Read_data_Ready) begin
          vld_d    = 1'b0;
          rd_cnt_d = sat_inc(rd_cnt_q);
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q  <= ST_IDLE;
      stall_q  <= 3'd0;
      lat_q    <= 16'd0;
      idx_q    <= '0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      rdata_q  <= 32'd0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      lat_q    <= lat_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign Mem_Req_Ready   = rdy_q;
  assign Read_data       = rdata_q;
  assign Read_data_Valid = vld_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;
  assign proto_err       = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - randomized self-checking bench for cpu_mem_responder

module tb_cpu_mem_responder;

  localparam int AW     = 12;
  localparam int RD_LAT = 1;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic [4:0]  random_mask;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        proto_err;

  always #5 sys_clk = ~sys_clk;

  cpu_mem_responder #(
    .ADDR_WIDTH (AW),
    .RAND_EN    (1'b1),
    .RD_LAT     (RD_LAT)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_reset_n     (sys_reset_n),
    .random_mask     (random_mask),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .proto_err       (proto_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory and expected counters
  logic [31:0] ref_mem [0:(1<<AW)-1];
  bit          written [0:(1<<AW)-1];
  int          exp_rd  = 0;
  int          exp_wr  = 0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  // One cycle to notice the request, then stall-1 cycles (at least one) of stalling.
  function automatic int req_delay(input int s);
    if (s == 0) return 1;
    return 1 + ((s - 1 > 1) ? s - 1 : 1);
  endfunction

  // Starts and ends on a negedge with no request asserted.
  task automatic xact(input string tag, input logic [31:0] addr, input logic wr, input logic rd,
                      input logic [31:0] wd, input logic [3:0] st, input logic [4:0] mask,
                      input int bp);
    int n;
    int k;
    logic [31:0] tmp;
    logic [31:0] exp_data;
    random_mask     = mask;
    Address         = addr;
    MemWrite        = wr;
    MemRead         = rd;
    Write_data      = wd;
    Write_strb      = st;
    Read_data_Ready = (bp == 0);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!Mem_Req_Ready && n < 40);
    chk({tag, ":rdy_dly"}, n, req_delay(int'(mask[2:0])));
    @(negedge sys_clk);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    k = widx(addr);
    chk({tag, ":rdy_drop"}, Mem_Req_Ready, 1'b0);
    if (wr) begin
      tmp = ref_mem[k];
      for (int b = 0; b < 4; b++) if (st[b]) tmp[8*b +: 8] = wd[8*b +: 8];
      ref_mem[k] = tmp;
      written[k] = 1'b1;
      exp_wr++;
      if (rd) exp_err = 1'b1;
      chk({tag, ":wr_cnt"}, wr_cnt, exp_wr);
      chk({tag, ":err"}, proto_err, exp_err);
      if (rd) begin
        repeat (3) @(negedge sys_clk);
        chk({tag, ":no_resp"}, Read_data_Valid, 1'b0);
      end
    end else begin
      exp_data = ref_mem[k];
      n = 0;
      while (!Read_data_Valid && n < 40) begin
        @(negedge sys_clk);
        n++;
      end
      chk({tag, ":rd_lat"}, n, RD_LAT + int'(mask[4:3]));
      for (int i = 0; i < bp; i++) begin
        chk({tag, ":hold_vld"}, Read_data_Valid, 1'b1);
        chk({tag, ":hold_data"}, Read_data, exp_data);
        chk({tag, ":hold_rdy"}, Mem_Req_Ready, 1'b0);
        @(negedge sys_clk);
      end
      chk({tag, ":rdata"}, Read_data, exp_data);
      Read_data_Ready = 1'b1;
      @(negedge sys_clk);
      exp_rd++;
      chk({tag, ":vld_drop"}, Read_data_Valid, 1'b0);
      chk({tag, ":rd_cnt"}, rd_cnt, exp_rd);
      Read_data_Ready = 1'b0;
    end
  endtask

  initial begin
    int idx;
    logic [31:0] a;
    sys_reset_n     = 1'b0;
    random_mask     = 5'd0;
    Address         = 32'd0;
    MemWrite        = 1'b0;
    MemRead         = 1'b0;
    Write_data      = 32'd0;
    Write_strb      = 4'd0;
    Read_data_Ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) written[i] = 1'b0;

    repeat (3) @(negedge sys_clk);
    chk("rst:rdy", Mem_Req_Ready, 1'b0);
    chk("rst:vld", Read_data_Valid, 1'b0);
    chk("rst:rdata", Read_data, 32'd0);
    chk("rst:rd_cnt", rd_cnt, 32'd0);
    chk("rst:wr_cnt", wr_cnt, 32'd0);
    chk("rst:err", proto_err, 1'b0);
    sys_reset_n = 1'b1;
    @(negedge sys_clk);

    xact("wr100", 32'h100, 1'b1, 1'b0, 32'h1234_5678, 4'hF, 5'd0, 0);
    xact("rd100", 32'h100, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 0);

    xact("wr40a", 32'h40, 1'b1, 1'b0, 32'hAABB_CCDD, 4'hF, 5'd0, 0);
    xact("wr40b", 32'h40, 1'b1, 1'b0, 32'h0000_1100, 4'b0010, 5'd0, 0);
    xact("rd40", 32'h40, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 0);

    xact("bp", 32'h100, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 10);

    xact("stall_wr", 32'h200, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 5'b11_101, 0);
    xact("stall_rd", 32'h200, 1'b0, 1'b1, 32'd0, 4'h0, 5'b11_101, 0);

    xact("both", 32'h8, 1'b1, 1'b1, 32'h5, 4'hF, 5'd0, 0);
    xact("rd8", 32'h8, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 0);

    // Reset while the read sits in its latency window
    random_mask = 5'b11_000;
    Address     = 32'h100;
    MemRead     = 1'b1;
    @(negedge sys_clk);
    chk("mid:rdy", Mem_Req_Ready, 1'b1);
    @(negedge sys_clk);
    MemRead = 1'b0;
    sys_reset_n = 1'b0;
    #1;
    chk("mid:vld", Read_data_Valid, 1'b0);
    chk("mid:rdy0", Mem_Req_Ready, 1'b0);
    chk("mid:rd_cnt", rd_cnt, 32'd0);
    chk("mid:wr_cnt", wr_cnt, 32'd0);
    chk("mid:err", proto_err, 1'b0);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    exp_rd  = 0;
    exp_wr  = 0;
    exp_err = 1'b0;
    @(negedge sys_clk);
    xact("post_rst", 32'h100, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 0);

    xact("wrap_wr", 32'h4000, 1'b1, 1'b0, 32'hCAFE_0001, 4'hF, 5'd0, 0);
    xact("wrap_rd0", 32'h0, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 0);
    xact("wrap_rd2", 32'h8000_4002, 1'b0, 1'b1, 32'd0, 4'h0, 5'd0, 0);

    // Request withdrawn during a stall
    chk("drop:err_pre", proto_err, 1'b0);
    random_mask = 5'b00_101;
    Address     = 32'h100;
    MemRead     = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("drop:rdy", Mem_Req_Ready, 1'b0);
    MemRead = 1'b0;
    @(negedge sys_clk);
    exp_err = 1'b1;
    chk("drop:err", proto_err, exp_err);
    @(negedge sys_clk);

    for (int it = 0; it < 40; it++) begin
      idx = 32 + int'($urandom_range(0, 15));
      a = ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if (!written[idx] || ($urandom_range(0, 1) == 0)) begin
        xact("rnd_wr", a, 1'b1, 1'b0, $urandom, written[idx] ? 4'($urandom) : 4'hF,
             5'($urandom), 0);
      end else begin
        xact("rnd_rd", a, 1'b0, 1'b1, 32'd0, 4'h0, 5'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the custom CPU data-memory valid/ready interface.
- Port names on that interface are the CPU's own: Address, MemWrite, Write_data, Write_strb, MemRead, Mem_Req_Ready, Read_data, Read_data_Valid, Read_data_Ready.
- Serves requests from an internal word RAM and inserts bounded pseudo-random stalls on both request acceptance and read return.
- Sits in the sim testbench in place of the wrapper, AXI arbiter and RAM chain, for fast core-level tests of handshake robustness.

Parameters:
- ADDR_WIDTH, 12, word-index width; RAM depth = 2**ADDR_WIDTH words.
- RAND_EN, 1, 1 = stalls taken from random_mask; 0 = zero-stall operation.
- RD_LAT, 1, fixed cycles from request acceptance to first Read_data_Valid; minimum 1.

Ports:
- sys_clk, input, 1, single clock.
- sys_reset_n, input, 1, reset, asynchronous, active-low.
- random_mask, input, 5, pseudo-random stall source from pseudo_random.
- Address, input, 32, byte address; word index = Address[ADDR_WIDTH+1:2].
- MemWrite, input, 1, write request.
- Write_data, input, 32, write data.
- Write_strb, input, 4, byte enables.
- MemRead, input, 1, read request.
- Mem_Req_Ready, output, 1, request accepted this cycle.
- Read_data, output, 32, read return data.
- Read_data_Valid, output, 1, read data valid.
- Read_data_Ready, input, 1, CPU accepts read data.
- rd_cnt, output, 32, completed reads, saturating.
- wr_cnt, output, 32, completed writes, saturating.
- proto_err, output, 1, sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - Mem_Req_Ready = 0, Read_data_Valid = 0, Read_data = 0, rd_cnt = 0, wr_cnt = 0, proto_err = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, REQ_STALL, ACCEPT, RD_WAIT, RD_RESP.
- IDLE:
  - On MemRead | MemWrite, load stall_cnt = RAND_EN ? random_mask[2:0] : 0.
  - Go to REQ_STALL if stall_cnt != 0, else ACCEPT.
- REQ_STALL:
  - Decrement stall_cnt; go to ACCEPT when it reaches 1.
  - If the request drops (MemRead = MemWrite = 0), set proto_err and return to IDLE.
- ACCEPT:
  - Mem_Req_Ready = 1 for exactly one cycle, registered.
  - Handshake completes on Mem_Req_Ready & (MemRead | MemWrite).
  - Write: RAM word updated per Write_strb byte lanes at the clock edge; wr_cnt++; back to IDLE.
  - Read: latch word index; lat_cnt = RD_LAT - 1 + (RAND_EN ? random_mask[4:3] : 0); go to RD_WAIT.
  - MemRead & MemWrite both high: set proto_err, perform the write only.
- RD_WAIT:
  - Count lat_cnt down; at 0, Read_data = RAM[latched index], Read_data_Valid = 1, go to RD_RESP.
  - Total latency from acceptance to valid = RD_LAT + random_mask[4:3] cycles.
- RD_RESP:
  - Read_data_Valid and Read_data held stable until Read_data_Ready.
  - On Valid & Ready: Valid drops next cycle, rd_cnt++, back to IDLE.
  - Mem_Req_Ready stays 0; no request is accepted while a read is outstanding.
- Read-after-write to the same word returns the new data, since the write lands before any later acceptance.
- Address handling:
  - Address[1:0] ignored.
  - Address bits above ADDR_WIDTH+1 ignored; addresses wrap modulo RAM depth.
- Counters saturate at 32'hFFFF_FFFF.
- proto_err: sticky; cleared only by reset.
- Reset mid-operation: outputs drop asynchronously; any in-flight read is discarded; a write not yet at its ACCEPT edge is not performed.

Decomposition:
- Shared package cpu_mem_resp_pkg holds:
  - FSM state encoding constants.
  - RD_LAT minimum constant.
  - Stall field bit positions in random_mask: [2:0] request stall, [4:3] read stall.
- One sub-module, cpu_mem_resp_ram: single-port, byte-write-enable word RAM; synchronous write, combinational read; no reset.

Test Plan:
- RAND_EN = 0, RD_LAT = 1: write 0x1234_5678 to 0x100 with strb 4'hF, then read 0x100 -> Mem_Req_Ready one cycle after each request; Read_data_Valid one cycle after read accept with 0x1234_5678; wr_cnt = 1, rd_cnt = 1.
- Byte strobes: write 0xAABB_CCDD to 0x40 (strb F), then 0x0000_1100 (strb 4'b0010) -> read 0x40 returns 0xAABB_11DD.
- Backpressure: hold Read_data_Ready = 0 for 10 cycles during a read -> Read_data_Valid held 10 cycles, Read_data stable, Mem_Req_Ready = 0 throughout; completes on the cycle Ready rises.
- Random stalls: random_mask = 5'b11_101 -> Mem_Req_Ready 5 cycles after request assertion; Read_data_Valid RD_LAT + 3 cycles after acceptance.
- Protocol errors:
  - MemRead & MemWrite both high at 0x8 with data 0x5 -> proto_err = 1, write performed, no read response.
  - Wrap: access 0x4000 with ADDR_WIDTH = 12 -> hits word 0.
- Reset mid-read: deassert sys_reset_n during RD_WAIT -> Read_data_Valid and Mem_Req_Ready 0 immediately; counters 0; after release, prior RAM data still readable.
